// File: rtl/vga_stack_view.sv
// vga_stack_view: VGA timing generator and renderer for a calculator stack.
// Each stack entry is drawn as one row of bit cells, with entry 0 (top of stack) in the first row.
// The numbers, depth and hl_en inputs are captured once per frame, so a frame never tears.
// The pipeline has a fixed latency of 2 clk from the counters to every output.
module vga_stack_view #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SW     = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SW     = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int ENTRIES  = 24,
  parameter int ENTRY_W  = 16,
  parameter int CELL_W   = 16,
  parameter int CELL_H   = 20,
  parameter int COLOR_W  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ENTRIES*ENTRY_W-1:0]    numbers,
  input  logic [$clog2(ENTRIES+1)-1:0]  depth,
  input  logic                          hl_en,
  output logic                          vga_h_sync,
  output logic                          vga_v_sync,
  output logic [COLOR_W-1:0]            vga_R,
  output logic [COLOR_W-1:0]            vga_G,
  output logic [COLOR_W-1:0]            vga_B,
  output logic                          frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int DW    = $clog2(ENTRIES + 1);
  localparam int CXW   = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int CYW   = (CELL_H > 1) ? $clog2(CELL_H) : 1;
  localparam int RIW   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int BIW   = (ENTRY_W > 1) ? $clog2(ENTRY_W) : 1;

  localparam logic [HW-1:0]  H_LAST    = HW'(H_TOT - 1);
  localparam logic [VW-1:0]  V_LAST    = VW'(V_TOT - 1);
  localparam logic [HW-1:0]  H_VIS_C   = HW'(H_VIS);
  localparam logic [VW-1:0]  V_VIS_C   = VW'(V_VIS);
  localparam logic [HW-1:0]  H_SS      = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0]  H_SE      = HW'(H_VIS + H_FP + H_SW);
  localparam logic [VW-1:0]  V_SS      = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0]  V_SE      = VW'(V_VIS + V_FP + V_SW);
  localparam logic [CXW-1:0] CW_LAST   = CXW'(CELL_W - 1);
  localparam logic [CYW-1:0] CH_LAST   = CYW'(CELL_H - 1);
  localparam logic [HW-1:0]  COLS_C    = HW'(ENTRY_W);
  localparam logic [VW-1:0]  ROWS_C    = VW'(ENTRIES);
  localparam logic [DW-1:0]  DEPTH_MAX = DW'(ENTRIES);
  localparam logic [BIW-1:0] BIT_TOP   = BIW'(ENTRY_W - 1);

  localparam logic [COLOR_W-1:0] C_FULL = '1;
  localparam logic [COLOR_W-1:0] C_ZERO = '0;
  localparam logic [COLOR_W-1:0] C_1    = COLOR_W'(1);
  localparam logic [COLOR_W-1:0] C_2    = COLOR_W'(2);
  localparam logic [COLOR_W-1:0] C_3    = COLOR_W'(3);
  localparam logic [COLOR_W-1:0] C_4    = COLOR_W'(4);

  // Stage 0 counters and the per-axis cell sub-counters
  logic [HW-1:0]  hcnt;
  logic [VW-1:0]  vcnt;
  logic [CXW-1:0] hsub;
  logic [CYW-1:0] vsub;
  logic [HW-1:0]  hcol;
  logic [VW-1:0]  vrow;

  // Per-frame shadow copies of the inputs
  logic [ENTRY_W-1:0] sh_num [ENTRIES];
  logic [DW-1:0]      sh_depth;
  logic               sh_hl;

  // Stage 0 decode
  logic           h_act, v_act, visible, in_grid, border, cell_bit, snap;
  logic [RIW-1:0] row_i;
  logic [BIW-1:0] bit_i;
  logic [ENTRY_W-1:0] ent;

  // Stage 1 registers
  logic s1_draw, s1_border, s1_empty, s1_bit, s1_hl, s1_hs, s1_vs, s1_fs;

  // Stage 2 next values
  logic [COLOR_W-1:0] r_nxt, g_nxt, b_nxt;

  assign snap = (hcnt == H_LAST) && (vcnt == V_LAST);

  // Pixel/line counters; sub-counters track hcnt%CELL_W and vcnt%CELL_H
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
      hsub <= '0;
      vsub <= '0;
      hcol <= '0;
      vrow <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      hsub <= '0;
      hcol <= '0;
      if (vcnt == V_LAST) begin
        vcnt <= '0;
        vsub <= '0;
        vrow <= '0;
      end else begin
        vcnt <= vcnt + 1'b1;
        if (vsub == CH_LAST) begin
          vsub <= '0;
          vrow <= vrow + 1'b1;
        end else begin
          vsub <= vsub + 1'b1;
        end
      end
    end else begin
      hcnt <= hcnt + 1'b1;
      if (hsub == CW_LAST) begin
        hsub <= '0;
        hcol <= hcol + 1'b1;
      end else begin
        hsub <= hsub + 1'b1;
      end
    end
  end

  // Capture the inputs on the last pixel of the frame, clamping depth to ENTRIES
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned e = 0; e < ENTRIES; e++) sh_num[e] <= '0;
      sh_depth <= '0;
      sh_hl    <= 1'b0;
    end else if (snap) begin
      for (int unsigned e = 0; e < ENTRIES; e++) sh_num[e] <= numbers[e*ENTRY_W +: ENTRY_W];
      sh_depth <= (depth > DEPTH_MAX) ? DEPTH_MAX : depth;
      sh_hl    <= hl_en;
    end
  end

  // Stage 0 decode: sync windows, visibility, cell position and selected bit
  always_comb begin
    h_act    = (hcnt >= H_SS) && (hcnt < H_SE);
    v_act    = (vcnt >= V_SS) && (vcnt < V_SE);
    visible  = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
    in_grid  = (hcol < COLS_C) && (vrow < ROWS_C);
    border   = (hsub == '0) || (vsub == '0);
    row_i    = vrow[RIW-1:0];
    bit_i    = BIT_TOP - hcol[BIW-1:0];
    ent      = '0;
    cell_bit = 1'b0;
    if (in_grid) begin
      ent      = sh_num[row_i];
      cell_bit = ent[bit_i];
    end
  end

  // Stage 1 register: cell classification plus sync/frame markers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_draw   <= 1'b0;
      s1_border <= 1'b0;
      s1_empty  <= 1'b0;
      s1_bit    <= 1'b0;
      s1_hl     <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_fs     <= 1'b0;
    end else begin
      s1_draw   <= visible && in_grid;
      s1_border <= border;
      s1_empty  <= vrow >= VW'(sh_depth);
      s1_bit    <= cell_bit;
      s1_hl     <= sh_hl && (vrow == '0);
      s1_hs     <= h_act;
      s1_vs     <= v_act;
      s1_fs     <= (hcnt == '0) && (vcnt == '0);
    end
  end

  // Colour rule, evaluated in priority order
  always_comb begin
    r_nxt = C_ZERO;
    g_nxt = C_ZERO;
    b_nxt = C_ZERO;
    if (s1_draw) begin
      if (s1_border) begin
        r_nxt = C_3; g_nxt = C_3; b_nxt = C_3;
      end else if (s1_empty) begin
        r_nxt = C_1; g_nxt = C_1; b_nxt = C_1;
      end else if (s1_hl) begin
        r_nxt = s1_bit ? C_FULL : C_4;
        g_nxt = s1_bit ? C_FULL : C_4;
      end else begin
        g_nxt = s1_bit ? C_FULL : C_2;
      end
    end
  end

  // Stage 2 output register
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_R       <= '0;
      vga_G       <= '0;
      vga_B       <= '0;
      vga_h_sync  <= ~SYNC_POL;
      vga_v_sync  <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      vga_R       <= r_nxt;
      vga_G       <= g_nxt;
      vga_B       <= b_nxt;
      vga_h_sync  <= s1_hs ? SYNC_POL : ~SYNC_POL;
      vga_v_sync  <= s1_vs ? SYNC_POL : ~SYNC_POL;
      frame_start <= s1_fs;
    end
  end

endmodule
